// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: load/store op codes, FSM states,
// byte-enable patterns and op-code decode helpers.
package mem_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } sz_t;

   // Big-endian lanes: bit 3 covers data bits 31:24 (offset 0).
   localparam logic [3:0] BE_BYTE0 = 4'b1000;
   localparam logic [3:0] BE_HI    = 4'b1100;
   localparam logic [3:0] BE_LO    = 4'b0011;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   // Unknown codes fall through to a word access.
   function automatic sz_t op_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic op_signed(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store steering, byte enables, misalign detect
// for the presented request, and select/extend for the returning load word.
module mem_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        req_op,
   input  logic [1:0]        req_off,
   input  logic [DATA_W-1:0] req_sdata,
   output logic              req_misalign,
   output logic [3:0]        req_be,
   output logic [DATA_W-1:0] req_wdata,
   input  logic [5:0]        ld_op,
   input  logic [1:0]        ld_off,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      req_be       = BE_WORD;
      req_wdata    = req_sdata;
      req_misalign = 1'b0;
      case (op_size(req_op))
         SZ_BYTE: begin
            req_be    = BE_BYTE0 >> req_off;
            req_wdata = {4{req_sdata[7:0]}};
         end
         SZ_HALF: begin
            req_be       = req_off[1] ? BE_LO : BE_HI;
            req_wdata    = {2{req_sdata[15:0]}};
            req_misalign = req_off[0];
         end
         default: req_misalign = |req_off;
      endcase
   end

   always_comb begin
      case (ld_off)
         2'd0:    ld_byte = ld_rdata[31:24];
         2'd1:    ld_byte = ld_rdata[23:16];
         2'd2:    ld_byte = ld_rdata[15:8];
         default: ld_byte = ld_rdata[7:0];
      endcase
      ld_half = ld_off[1] ? ld_rdata[15:0] : ld_rdata[31:16];
      case (op_size(ld_op))
         SZ_BYTE: ld_data = op_signed(ld_op) ? {{24{ld_byte[7]}}, ld_byte}
                                             : {24'd0, ld_byte};
         SZ_HALF: ld_data = op_signed(ld_op) ? {{16{ld_half[15]}}, ld_half}
                                             : {16'd0, ld_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-cache loads/stores over req/ready,
// stalls upstream while an access is outstanding, registers the WB result.
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       Instr1_IN,
   input  logic [31:0]       Instr1_PC_IN,
   input  logic [DATA_W-1:0] ALU_result1_IN,
   input  logic [4:0]        WriteRegister1_IN,
   input  logic [DATA_W-1:0] MemWriteData1_IN,
   input  logic              RegWrite1_IN,
   input  logic [5:0]        ALU_Control1_IN,
   input  logic              MemRead1_IN,
   input  logic              MemWrite1_IN,
   output logic              dc_req,
   output logic              dc_we,
   output logic [ADDR_W-1:0] dc_addr,
   output logic [3:0]        dc_be,
   output logic [DATA_W-1:0] dc_wdata,
   input  logic              dc_ready,
   input  logic [DATA_W-1:0] dc_rdata,
   output logic [31:0]       Instr1_OUT,
   output logic [31:0]       Instr1_PC_OUT,
   output logic [DATA_W-1:0] WriteData1_OUT,
   output logic [4:0]        WriteRegister1_OUT,
   output logic              RegWrite1_OUT,
   output logic              AddrErr1_OUT,
   output logic [4:0]        BypassReg1_MEMEXE,
   output logic [DATA_W-1:0] BypassData1_MEMEXE,
   output logic              BypassValid1_MEMEXE,
   output logic              stall_OUT
);

   state_t            state_q, state_d;
   logic              mem_op, misalign_c, addr_err_c;
   logic              stall_c, load_out, latch_req, latch_rd;
   logic              out_rw_c, out_err_c;
   logic [DATA_W-1:0] out_wdata_c;
   logic [3:0]        be_c;
   logic [DATA_W-1:0] wdata_c, ld_ext_c;

   logic [ADDR_W-1:0] addr_p1;
   logic [3:0]        be_p1;
   logic [DATA_W-1:0] wdata_p1;
   logic              we_p1;
   logic [5:0]        op_p1;
   logic [1:0]        off_p1;
   logic [DATA_W-1:0] ld_data_p2;

   mem_align #(.DATA_W(DATA_W)) u_align (
      .req_op       (ALU_Control1_IN),
      .req_off      (ALU_result1_IN[1:0]),
      .req_sdata    (MemWriteData1_IN),
      .req_misalign (misalign_c),
      .req_be       (be_c),
      .req_wdata    (wdata_c),
      .ld_op        (op_p1),
      .ld_off       (off_p1),
      .ld_rdata     (dc_rdata),
      .ld_data      (ld_ext_c)
   );

   assign mem_op     = MemRead1_IN | MemWrite1_IN;
   assign addr_err_c = mem_op & misalign_c;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      stall_c     = 1'b0;
      dc_req      = 1'b0;
      load_out    = 1'b0;
      latch_req   = 1'b0;
      latch_rd    = 1'b0;
      out_wdata_c = ALU_result1_IN;
      out_rw_c    = RegWrite1_IN;
      out_err_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op && !misalign_c) begin
               stall_c   = 1'b1;
               latch_req = 1'b1;
               state_d   = WAIT;
            end else begin
               load_out  = 1'b1;
               out_err_c = addr_err_c;
               if (addr_err_c) out_rw_c = 1'b0;
            end
         end
         WAIT: begin
            dc_req  = 1'b1;
            stall_c = 1'b1;
            if (dc_ready) begin
               latch_rd = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            // Upstream was frozen, so the inputs still carry this access.
            load_out    = 1'b1;
            out_wdata_c = ld_data_p2;
            out_rw_c    = RegWrite1_IN & ~we_p1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A pipeline held in reset must not be frozen by a presented memory op.
   assign stall_OUT = stall_c & RESET;

   // ---- request latch (IDLE -> WAIT) ----
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         addr_p1  <= '0;
         be_p1    <= '0;
         wdata_p1 <= '0;
         we_p1    <= 1'b0;
         op_p1    <= '0;
         off_p1   <= '0;
      end else if (latch_req) begin
         addr_p1  <= {ALU_result1_IN[ADDR_W-1:2], 2'b00};
         be_p1    <= be_c;
         wdata_p1 <= wdata_c;
         we_p1    <= MemWrite1_IN;
         op_p1    <= ALU_Control1_IN;
         off_p1   <= ALU_result1_IN[1:0];
      end
   end

   // ---- load data capture (WAIT -> DONE) ----
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)        ld_data_p2 <= '0;
      else if (latch_rd) ld_data_p2 <= we_p1 ? '0 : ld_ext_c;
   end

   // ---- writeback output register ----
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Instr1_OUT         <= '0;
         Instr1_PC_OUT      <= '0;
         WriteData1_OUT     <= '0;
         WriteRegister1_OUT <= '0;
         RegWrite1_OUT      <= 1'b0;
         AddrErr1_OUT       <= 1'b0;
      end else begin
         AddrErr1_OUT <= out_err_c;
         if (load_out) begin
            Instr1_OUT         <= Instr1_IN;
            Instr1_PC_OUT      <= Instr1_PC_IN;
            WriteData1_OUT     <= out_wdata_c;
            WriteRegister1_OUT <= WriteRegister1_IN;
            RegWrite1_OUT      <= out_rw_c;
         end
      end
   end

   assign dc_we    = we_p1;
   assign dc_addr  = addr_p1;
   assign dc_be    = be_p1;
   assign dc_wdata = wdata_p1;

   assign BypassReg1_MEMEXE   = WriteRegister1_OUT;
   assign BypassData1_MEMEXE  = WriteData1_OUT;
   assign BypassValid1_MEMEXE = RegWrite1_OUT && (WriteRegister1_OUT != 5'd0);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized ops against an
// arithmetic reference model of load extension and store steering.
module tb_mem_stage;
   import mem_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
   logic [4:0]  WriteRegister1_IN;
   logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
   logic [5:0]  ALU_Control1_IN;
   logic        dc_req, dc_we, dc_ready;
   logic [31:0] dc_addr, dc_wdata, dc_rdata;
   logic [3:0]  dc_be;
   logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, BypassData1_MEMEXE;
   logic [4:0]  WriteRegister1_OUT, BypassReg1_MEMEXE;
   logic        RegWrite1_OUT, AddrErr1_OUT, BypassValid1_MEMEXE, stall_OUT;

   mem_stage dut (
      .CLK(CLK), .RESET(RESET),
      .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
      .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
      .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
      .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
      .MemWrite1_IN(MemWrite1_IN),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_be(dc_be),
      .dc_wdata(dc_wdata), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
      .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
      .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
      .RegWrite1_OUT(RegWrite1_OUT), .AddrErr1_OUT(AddrErr1_OUT),
      .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
      .BypassValid1_MEMEXE(BypassValid1_MEMEXE), .stall_OUT(stall_OUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [31:0] e_instr, e_pc, e_wd;
   logic [4:0]  e_wreg;
   logic        e_rw, e_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string ph);
      chk({ph, ".instr"}, Instr1_OUT, e_instr);
      chk({ph, ".pc"}, Instr1_PC_OUT, e_pc);
      chk({ph, ".wdata"}, WriteData1_OUT, e_wd);
      chk({ph, ".wreg"}, 32'(WriteRegister1_OUT), 32'(e_wreg));
      chk({ph, ".regwrite"}, 32'(RegWrite1_OUT), 32'(e_rw));
      chk({ph, ".addrerr"}, 32'(AddrErr1_OUT), 32'(e_err));
      chk({ph, ".byp_reg"}, 32'(BypassReg1_MEMEXE), 32'(e_wreg));
      chk({ph, ".byp_data"}, BypassData1_MEMEXE, e_wd);
      chk({ph, ".byp_valid"}, 32'(BypassValid1_MEMEXE), 32'(e_rw && (e_wreg != 5'd0)));
   endtask

   // Reference model: access size in bytes, unknown codes are words.
   function automatic int m_size(input logic [5:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] op, input int off, input logic [31:0] rd);
      int sz;
      logic [31:0] v;
      sz = m_size(op);
      if (sz == 4) return rd;
      v = (rd >> (8 * (4 - sz - off))) & ((sz == 1) ? 32'hFF : 32'hFFFF);
      if (op == OP_LB && v >= 32'd128)   v = v - 32'd256;
      if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
      return v;
   endfunction

   function automatic logic [3:0] m_be(input logic [5:0] op, input int off);
      int sz;
      sz = m_size(op);
      if (sz == 1) return 4'(32'd1 << (3 - off));
      if (sz == 2) return (off == 0) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] sd);
      int sz;
      sz = m_size(op);
      if (sz == 1) return (sd & 32'hFF) * 32'h01010101;
      if (sz == 2) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   // Entered just after a rising edge; leaves just after the edge that updates the outputs.
   task automatic do_instr(input string tag, input logic [5:0] op, input logic mr, input logic mw,
                           input logic rw, input logic [4:0] wr, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [31:0] rd, input int waits);
      int off, sz, stalls;
      logic mem, mis;
      logic [31:0] instr, pc;
      instr = $urandom;
      pc    = $urandom;
      off   = int'(alu[1:0]);
      sz    = m_size(op);
      mem   = mr | mw;
      mis   = mem && ((off % sz) != 0);
      Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = alu;
      WriteRegister1_IN = wr; MemWriteData1_IN = sd; RegWrite1_IN = rw;
      ALU_Control1_IN = op; MemRead1_IN = mr; MemWrite1_IN = mw;
      dc_ready = 1'($urandom_range(0, 1));
      dc_rdata = $urandom;
      @(negedge CLK);
      if (!mem || mis) begin
         chk({tag, ".stall"}, 32'(stall_OUT), 32'd0);
         chk({tag, ".req"}, 32'(dc_req), 32'd0);
         @(posedge CLK); #1;
         dc_ready = 1'b0;
         e_instr = instr; e_pc = pc; e_wreg = wr; e_wd = alu;
         e_rw = rw && !mis; e_err = mis;
         check_outs({tag, ".out"});
      end else begin
         chk({tag, ".idle_stall"}, 32'(stall_OUT), 32'd1);
         chk({tag, ".idle_req"}, 32'(dc_req), 32'd0);
         stalls = 1;
         @(posedge CLK); #1;
         e_err = 1'b0;
         for (int k = 1; k <= waits; k++) begin
            dc_ready = (k == waits);
            dc_rdata = (k == waits) ? rd : $urandom;
            @(negedge CLK);
            chk({tag, ".req"}, 32'(dc_req), 32'd1);
            chk({tag, ".we"}, 32'(dc_we), 32'(mw));
            chk({tag, ".addr"}, dc_addr, alu & ~32'd3);
            if (mw) begin
               chk({tag, ".be"}, 32'(dc_be), 32'(m_be(op, off)));
               chk({tag, ".dc_wdata"}, dc_wdata, m_wdata(op, sd));
            end
            check_outs({tag, ".hold"});
            stalls += int'(stall_OUT);
            @(posedge CLK); #1;
         end
         dc_ready = 1'($urandom_range(0, 1));
         dc_rdata = $urandom;
         @(negedge CLK);
         chk({tag, ".done_stall"}, 32'(stall_OUT), 32'd0);
         chk({tag, ".done_req"}, 32'(dc_req), 32'd0);
         chk({tag, ".stall_cycles"}, 32'(stalls), 32'(waits + 1));
         @(posedge CLK); #1;
         dc_ready = 1'b0;
         e_instr = instr; e_pc = pc; e_wreg = wr;
         e_wd = mw ? 32'd0 : m_load(op, off, rd);
         e_rw = rw && !mw; e_err = 1'b0;
         check_outs({tag, ".out"});
      end
   endtask

   logic [5:0] ops [10];
   initial begin
      int sel, waits;
      logic mr, mw;
      logic [31:0] addr;
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'h3F, 6'h01};

      RESET = 1'b0; dc_ready = 1'b0; dc_rdata = '0;
      Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; WriteRegister1_IN = '0;
      MemWriteData1_IN = '0; RegWrite1_IN = 1'b0; ALU_Control1_IN = '0;
      MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
      e_instr = '0; e_pc = '0; e_wd = '0; e_wreg = '0; e_rw = 1'b0; e_err = 1'b0;

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_outs("reset");
      chk("reset.req", 32'(dc_req), 32'd0);
      chk("reset.stall", 32'(stall_OUT), 32'd0);
      RESET = 1'b1;
      dc_ready = 1'b1;
      @(posedge CLK); #1;
      dc_ready = 1'b0;
      chk("post_rst.req", 32'(dc_req), 32'd0);
      check_outs("post_rst");

      do_instr("lw",     OP_LW,  1'b1, 1'b0, 1'b1, 5'd7,  32'h1000, 32'h0, 32'hDEADBEEF, 3);
      do_instr("lb",     OP_LB,  1'b1, 1'b0, 1'b1, 5'd8,  32'h2001, 32'h0, 32'h12803456, 1);
      do_instr("lbu",    OP_LBU, 1'b1, 1'b0, 1'b1, 5'd8,  32'h2001, 32'h0, 32'h12803456, 2);
      do_instr("sh",     OP_SH,  1'b0, 1'b1, 1'b1, 5'd9,  32'h3002, 32'h0000ABCD, 32'h0, 2);
      do_instr("lw_mis", OP_LW,  1'b1, 1'b0, 1'b1, 5'd10, 32'h4002, 32'h0, 32'h0, 1);
      do_instr("add",    6'h01,  1'b0, 1'b0, 1'b1, 5'd3,  32'h55,   32'h0, 32'h0, 1);
      do_instr("lw_fast", OP_LW, 1'b1, 1'b0, 1'b1, 5'd4,  32'h5004, 32'h0, 32'hCAFEF00D, 1);
      do_instr("lh_lo",  OP_LH,  1'b1, 1'b0, 1'b1, 5'd5,  32'h5006, 32'h0, 32'h1234F00D, 1);
      do_instr("lhu_hi", OP_LHU, 1'b1, 1'b0, 1'b1, 5'd5,  32'h5004, 32'h0, 32'h9234F00D, 1);
      do_instr("lh_mis", OP_LH,  1'b1, 1'b0, 1'b1, 5'd5,  32'h5003, 32'h0, 32'h0, 1);
      do_instr("sb3",    OP_SB,  1'b0, 1'b1, 1'b1, 5'd6,  32'h6003, 32'h000000A5, 32'h0, 1);
      do_instr("sw",     OP_SW,  1'b0, 1'b1, 1'b0, 5'd6,  32'h6008, 32'h89ABCDEF, 32'h0, 4);
      do_instr("unk_ld", 6'h3F,  1'b1, 1'b0, 1'b1, 5'd11, 32'h700C, 32'h0, 32'h87654321, 2);
      do_instr("lw_r0",  OP_LW,  1'b1, 1'b0, 1'b1, 5'd0,  32'h7010, 32'h0, 32'h11111111, 1);

      for (int i = 0; i < 60; i++) begin
         sel   = $urandom_range(0, 9);
         mr    = (sel <= 4);
         mw    = (sel >= 5 && sel <= 7);
         if (sel == 8) begin
            mr = 1'($urandom_range(0, 1));
            mw = !mr;
         end
         addr  = $urandom;
         if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
         waits = $urandom_range(1, 4);
         do_instr("rnd", ops[sel], mr, mw, 1'($urandom_range(0, 1)), 5'($urandom),
                  addr, $urandom, $urandom, waits);
      end

      // Reset while an access is outstanding.
      Instr1_IN = 32'h0BADC0DE; ALU_result1_IN = 32'h6000; ALU_Control1_IN = OP_LW;
      MemRead1_IN = 1'b1; MemWrite1_IN = 1'b0; RegWrite1_IN = 1'b1; WriteRegister1_IN = 5'd12;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst_wait.req_before", 32'(dc_req), 32'd1);
      #2 RESET = 1'b0;
      #1;
      e_instr = '0; e_pc = '0; e_wd = '0; e_wreg = '0; e_rw = 1'b0; e_err = 1'b0;
      chk("rst_wait.req", 32'(dc_req), 32'd0);
      chk("rst_wait.stall", 32'(stall_OUT), 32'd0);
      check_outs("rst_wait");
      Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; ALU_Control1_IN = '0;
      MemRead1_IN = 1'b0; RegWrite1_IN = 1'b0; WriteRegister1_IN = '0; MemWriteData1_IN = '0;
      dc_ready = 1'b1; dc_rdata = 32'hFFFFFFFF;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      dc_ready = 1'b0;
      @(negedge CLK);
      chk("rst_after.req", 32'(dc_req), 32'd0);
      check_outs("rst_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
